// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin grant held for a whole packet (until req_last) or MAX_BURST
// bytes (0 = unlimited). A new byte is issued only after the previous one
// reports uart_tx_complete.
//
// Optional feature macro: UART_ARB_TAG_EN
//   When defined, each new grant first sends a header byte
//   {4'hA, 1'b0, grant_id[2:0]} through the transmitter before any data.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[i]      requester i presents a byte on req_data[8i+7:8i]
//   req_data          packed request bytes
//   req_last[i]       presented byte ends requester i's packet
//   req_ready[i]      byte of requester i accepted this cycle (combinational)
//   uart_tx_data      byte to transmitter, stable from tx_rdy to tx_complete
//   uart_tx_rdy       one-cycle start pulse to transmitter
//   uart_tx_complete  one-cycle frame-done pulse from transmitter
//   busy              FSM is not idle
//   grant_id          current/last granted requester
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_rdy,
    input  logic                 uart_tx_complete,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    // Burst counter must hold MAX_BURST itself without wrapping.
    localparam int unsigned BC_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
`ifdef UART_ARB_TAG_EN
        ST_TAG,
        ST_TAG_WAIT,
`endif
        ST_IDLE,
        ST_LOAD,
        ST_WAIT
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_grant_id;
    logic [7:0]      r_tx_data;
    logic            r_tx_rdy;
    logic            r_busy;
    logic            r_last;
    logic [BC_W-1:0] r_burst_cnt;

    logic            w_found;
    logic [ID_W-1:0] w_next_id;
    logic            w_hs;
    logic            w_burst_done;
    logic [7:0]      w_sel_byte;
`ifdef UART_ARB_TAG_EN
    logic [7:0]      w_tag_byte;
`endif

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [ID_W-1:0] idx;
        w_found   = 1'b0;
        w_next_id = r_grant_id;
        idx       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((32'(r_grant_id) + i) % NUM_REQ);
            if (!w_found && req_valid[idx]) begin
                w_found   = 1'b1;
                w_next_id = idx;
            end
        end
    end

    // Only the granted requester can be accepted, and only in LOAD.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_LOAD) begin
            req_ready[r_grant_id] = req_valid[r_grant_id];
        end
    end

    assign w_hs         = (r_state == ST_LOAD) && req_valid[r_grant_id];
    assign w_sel_byte   = req_data[32'(r_grant_id) * 8 +: 8];
    assign w_burst_done = (MAX_BURST != 0) && (r_burst_cnt == BC_W'(MAX_BURST));
`ifdef UART_ARB_TAG_EN
    assign w_tag_byte   = {4'hA, 1'b0, 3'(r_grant_id)};
`endif

    // Main FSM with registered transmitter-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= ID_W'(NUM_REQ - 1);
            r_tx_data   <= 8'h00;
            r_tx_rdy    <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_tx_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_next_id;
                        r_busy     <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        r_state    <= ST_TAG;
`else
                        r_state    <= ST_LOAD;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                ST_TAG: begin
                    r_tx_data <= w_tag_byte;
                    r_tx_rdy  <= 1'b1;
                    r_state   <= ST_TAG_WAIT;
                end
                ST_TAG_WAIT: begin
                    if (uart_tx_complete) begin
                        r_state <= ST_LOAD;
                    end
                end
`endif
                ST_LOAD: begin
                    // A stalled requester keeps the grant indefinitely.
                    if (w_hs) begin
                        r_tx_data <= w_sel_byte;
                        r_last    <= req_last[r_grant_id];
                        if (MAX_BURST != 0) begin
                            r_burst_cnt <= r_burst_cnt + BC_W'(1);
                        end
                        r_tx_rdy  <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (uart_tx_complete) begin
                        if (r_last || w_burst_done) begin
                            r_burst_cnt <= '0;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_tx_data = r_tx_data;
    assign uart_tx_rdy  = r_tx_rdy;
    assign busy         = r_busy;
    assign grant_id     = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
// Per-requester byte queues feed the DUT; a transmitter model answers each
// uart_tx_rdy with uart_tx_complete about 10 cycles later and logs bytes.
// Expected byte/grant sequences are hand-written in each test task.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = 2;
`ifdef UART_ARB_TAG_EN
    localparam int TAGN = 1;
`else
    localparam int TAGN = 0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_rdy;
    logic                 uart_tx_complete;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(MAX_BURST),
        .ID_W     (ID_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .uart_tx_data    (uart_tx_data),
        .uart_tx_rdy     (uart_tx_rdy),
        .uart_tx_complete(uart_tx_complete),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // stimulus and logs
    logic [8:0]         pkt_q [NUM_REQ][$];   // {last, data}
    logic [NUM_REQ-1:0] hold = '0;
    logic [NUM_REQ-1:0] hs_prev = '0;
    int                 vstart [NUM_REQ];
    logic [7:0]         sent_q[$];
    int                 sent_cyc[$];
    logic [7:0]         acc_data[$];
    int                 acc_gid[$];
    int                 acc_cyc[$];
    int                 cd = 0;
    int                 ovl_cnt = 0;
    int                 stab_err = 0;

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) if (pkt_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        sent_q.delete(); sent_cyc.delete();
        acc_data.delete(); acc_gid.delete(); acc_cyc.delete();
    endtask

    // Requester driver: present queue heads, pop after each handshake.
    initial begin
        logic [8:0] e;
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (hs_prev[i] && pkt_q[i].size() > 0) void'(pkt_q[i].pop_front());
            hs_prev = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!hold[i] && pkt_q[i].size() > 0) begin
                    e = pkt_q[i][0];
                    if (!req_valid[i]) vstart[i] = cyc;
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = e[7:0];
                    req_last[i]        = e[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            #1;
            if (rst_n) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        hs_prev[i] = 1'b1;
                        acc_data.push_back(req_data[8*i +: 8]);
                        acc_gid.push_back(int'(grant_id));
                        acc_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // Transmitter model: complete pulse 10 cycles after each start pulse.
    initial begin
        uart_tx_complete = 1'b0;
        forever begin
            @(negedge clk);
            uart_tx_complete = 1'b0;
            if (!rst_n) begin
                cd = 0;
            end else if (uart_tx_rdy) begin
                if (cd > 0) ovl_cnt++;
                sent_q.push_back(uart_tx_data);
                sent_cyc.push_back(cyc);
                cd = 10;
            end else if (cd > 0) begin
                if (sent_q.size() > 0 && uart_tx_data !== sent_q[$]) stab_err++;
                cd--;
                if (cd == 0) uart_tx_complete = 1'b1;
            end
        end
    end

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #2;
            if (!busy && cd == 0 && all_empty()) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++; if (uart_tx_rdy !== 1'b0) begin errors++; $display("FAIL reset_tx_rdy got=%b want=0", uart_tx_rdy); end
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", uart_tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant_id got=%0d want=3", grant_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        bit seen;
        clear_logs();
        pkt_q[0].push_back({1'b1, 8'h55});
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #2;
            if (uart_tx_complete && sent_q.size() == 1 + TAGN) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL single_complete_timeout got=none want=complete"); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_complete got=%b want=1", busy); end
        @(negedge clk); #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_complete got=%b want=0", busy); end
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=busy want=idle"); end
        checks++;
        if (sent_q.size() != 1 + TAGN) begin
            errors++; $display("FAIL single_count got=%0d want=%0d", sent_q.size(), 1 + TAGN);
        end else if (sent_q[TAGN] !== 8'h55) begin
            errors++; $display("FAIL single_data got=%h want=55", sent_q[TAGN]);
        end
`ifdef UART_ARB_TAG_EN
        checks++; if (sent_q.size() > 0 && sent_q[0] !== 8'hA0) begin errors++; $display("FAIL single_tag got=%h want=a0", sent_q[0]); end
`else
        checks++; if (sent_cyc.size() == 0 || sent_cyc[0] - vstart[0] != 2) begin errors++; $display("FAIL single_tx_rdy_latency got=%0d want=2", sent_cyc.size() ? sent_cyc[0] - vstart[0] : -1); end
        checks++; if (acc_cyc.size() == 0 || acc_cyc[0] - vstart[0] != 1) begin errors++; $display("FAIL single_ready_latency got=%0d want=1", acc_cyc.size() ? acc_cyc[0] - vstart[0] : -1); end
`endif
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_id got=%0d want=0", grant_id); end
    endtask

    task automatic test_two_requesters();
        bit ok;
        logic [7:0] exp[$];
        int egid[$];
        clear_logs();
        pkt_q[1].push_back({1'b0, 8'h11}); pkt_q[1].push_back({1'b1, 8'h12});
        pkt_q[2].push_back({1'b0, 8'h21}); pkt_q[2].push_back({1'b1, 8'h22});
        if (TAGN != 0) exp.push_back(8'hA1);
        exp.push_back(8'h11); exp.push_back(8'h12);
        if (TAGN != 0) exp.push_back(8'hA2);
        exp.push_back(8'h21); exp.push_back(8'h22);
        egid = '{1, 1, 2, 2};
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_timeout got=busy want=idle"); end
        checks++;
        if (sent_q.size() != exp.size()) begin
            errors++; $display("FAIL two_count got=%0d want=%0d", sent_q.size(), exp.size());
        end else for (int k = 0; k < exp.size(); k++) begin
            checks++; if (sent_q[k] !== exp[k]) begin errors++; $display("FAIL two_byte%0d got=%h want=%h", k, sent_q[k], exp[k]); end
        end
        checks++;
        if (acc_gid.size() != egid.size()) begin
            errors++; $display("FAIL two_accept_count got=%0d want=%0d", acc_gid.size(), egid.size());
        end else for (int k = 0; k < egid.size(); k++) begin
            checks++; if (acc_gid[k] != egid[k]) begin errors++; $display("FAIL two_gid%0d got=%0d want=%0d", k, acc_gid[k], egid[k]); end
        end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL two_grant_id got=%0d want=2", grant_id); end
    endtask

    task automatic test_max_burst();
        bit ok;
        logic [7:0] exp[$];
        int egid[$];
        clear_logs();
        for (int b = 1; b <= 6; b++) pkt_q[0].push_back({(b == 6), 8'(b)});
        for (int n = 0; n < 300 && acc_data.size() == 0; n++) begin @(negedge clk); #2; end
        pkt_q[3].push_back({1'b1, 8'h31});
        if (TAGN != 0) exp.push_back(8'hA0);
        exp.push_back(8'h01); exp.push_back(8'h02); exp.push_back(8'h03); exp.push_back(8'h04);
        if (TAGN != 0) exp.push_back(8'hA3);
        exp.push_back(8'h31);
        if (TAGN != 0) exp.push_back(8'hA0);
        exp.push_back(8'h05); exp.push_back(8'h06);
        egid = '{0, 0, 0, 0, 3, 0, 0};
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got=busy want=idle"); end
        checks++;
        if (sent_q.size() != exp.size()) begin
            errors++; $display("FAIL burst_count got=%0d want=%0d", sent_q.size(), exp.size());
        end else for (int k = 0; k < exp.size(); k++) begin
            checks++; if (sent_q[k] !== exp[k]) begin errors++; $display("FAIL burst_byte%0d got=%h want=%h", k, sent_q[k], exp[k]); end
        end
        checks++;
        if (acc_gid.size() != egid.size()) begin
            errors++; $display("FAIL burst_accept_count got=%0d want=%0d", acc_gid.size(), egid.size());
        end else for (int k = 0; k < egid.size(); k++) begin
            checks++; if (acc_gid[k] != egid[k]) begin errors++; $display("FAIL burst_gid%0d got=%0d want=%0d", k, acc_gid[k], egid[k]); end
        end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL burst_grant_id got=%0d want=0", grant_id); end
    endtask

    task automatic test_stall();
        bit ok;
        int steal;
        logic [7:0] exp[$];
        int egid[$];
        clear_logs();
        pkt_q[0].push_back({1'b0, 8'h71}); pkt_q[0].push_back({1'b0, 8'h72}); pkt_q[0].push_back({1'b1, 8'h73});
        for (int n = 0; n < 300 && acc_data.size() == 0; n++) begin @(negedge clk); #2; end
        hold[0] = 1'b1;
        pkt_q[1].push_back({1'b1, 8'h91});
        steal = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #2;
            if (req_ready != 4'b0000) steal++;
        end
        checks++; if (steal != 0) begin errors++; $display("FAIL stall_ready_seen got=%0d want=0", steal); end
        checks++; if (sent_q.size() != 1 + TAGN) begin errors++; $display("FAIL stall_tx_count got=%0d want=%0d", sent_q.size(), 1 + TAGN); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b want=1", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL stall_grant_id got=%0d want=0", grant_id); end
        hold[0] = 1'b0;
        if (TAGN != 0) exp.push_back(8'hA0);
        exp.push_back(8'h71); exp.push_back(8'h72); exp.push_back(8'h73);
        if (TAGN != 0) exp.push_back(8'hA1);
        exp.push_back(8'h91);
        egid = '{0, 0, 0, 1};
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=busy want=idle"); end
        checks++;
        if (sent_q.size() != exp.size()) begin
            errors++; $display("FAIL stall_count got=%0d want=%0d", sent_q.size(), exp.size());
        end else for (int k = 0; k < exp.size(); k++) begin
            checks++; if (sent_q[k] !== exp[k]) begin errors++; $display("FAIL stall_byte%0d got=%h want=%h", k, sent_q[k], exp[k]); end
        end
        checks++;
        if (acc_gid.size() != egid.size()) begin
            errors++; $display("FAIL stall_accept_count got=%0d want=%0d", acc_gid.size(), egid.size());
        end else for (int k = 0; k < egid.size(); k++) begin
            checks++; if (acc_gid[k] != egid[k]) begin errors++; $display("FAIL stall_gid%0d got=%0d want=%0d", k, acc_gid[k], egid[k]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        clear_logs();
        pkt_q[2].push_back({1'b0, 8'hB1}); pkt_q[2].push_back({1'b1, 8'hB2});
        for (int n = 0; n < 300 && sent_q.size() < 1 + TAGN; n++) begin @(negedge clk); #2; end
        repeat (3) @(negedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (uart_tx_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_tx_rdy got=%b want=0", uart_tx_rdy); end
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data got=%h want=00", uart_tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rstmid_grant_id got=%0d want=3", grant_id); end
        for (int i = 0; i < NUM_REQ; i++) pkt_q[i].delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        clear_logs();
        @(negedge clk); #2;
        pkt_q[2].push_back({1'b1, 8'hC1});
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got=busy want=idle"); end
        checks++;
        if (sent_q.size() != 1 + TAGN) begin
            errors++; $display("FAIL rstmid_count got=%0d want=%0d", sent_q.size(), 1 + TAGN);
        end else if (sent_q[TAGN] !== 8'hC1) begin
            errors++; $display("FAIL rstmid_data got=%h want=c1", sent_q[TAGN]);
        end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL rstmid_grant_after got=%0d want=2", grant_id); end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        bit ok;
        clear_logs();
        pkt_q[3].push_back({1'b1, 8'h41});
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tag_timeout got=busy want=idle"); end
        checks++;
        if (sent_q.size() != 2) begin
            errors++; $display("FAIL tag_count got=%0d want=2", sent_q.size());
        end else begin
            checks++; if (sent_q[0] !== 8'hA3) begin errors++; $display("FAIL tag_header got=%h want=a3", sent_q[0]); end
            checks++; if (sent_q[1] !== 8'h41) begin errors++; $display("FAIL tag_data got=%h want=41", sent_q[1]); end
            checks++; if (acc_cyc.size() != 1 || acc_cyc[0] <= sent_cyc[0]) begin errors++; $display("FAIL tag_ready_during_header got=%0d accepts want=1 after header", acc_cyc.size()); end
        end
        checks++; if (acc_data.size() != 1 || acc_data[0] !== 8'h41) begin errors++; $display("FAIL tag_accepted got=%0d bytes want=1 (41)", acc_data.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two_requesters();
        test_max_burst();
        test_stall();
        test_reset_mid_frame();
`ifdef UART_ARB_TAG_EN
        test_tag();
`endif
        checks++; if (ovl_cnt != 0) begin errors++; $display("FAIL tx_rdy_during_frame got=%0d want=0", ovl_cnt); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL tx_data_unstable got=%0d want=0", stab_err); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
